rf_write_arbiter: RTL and testbench

- Write-side controller for the pipelined OTTER register file.
- Merges two result streams onto the single RF write port: the in-order pipeline writeback, and a long-latency unit (divider / slow load) that arrives through a valid/ready handshake.
- Keeps a 32-entry scoreboard of registers with outstanding long-latency results, so decode can stall on RAW hazards.
- Drives the RF's WE3/A3/WD3 from registered outputs.

---
 rtl/otter_rf_pkg.sv | 22 ++
 rtl/rf_wr_fifo.sv | 59 +++++
 rtl/rf_write_arbiter.sv | 142 ++++++++++++++
 tb/tb_rf_write_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_rf_pkg.sv
// ----------------------------------------------------------------------------
// otter_rf_pkg
// Shared types and sizes for the OTTER register-file write side.
//   XLEN     : register data width
//   REG_AW   : register address width (x0..x31)
//   NUM_REGS : number of architectural registers
//   rf_wr_t  : one pending RF write (destination, value, and whether it came
//              from the long-latency unit rather than the in-order pipeline)
// ----------------------------------------------------------------------------
package otter_rf_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
    logic              from_lu;
  } rf_wr_t;

endpackage

// File: rtl/rf_wr_fifo.sv
// ----------------------------------------------------------------------------
// rf_wr_fifo
// Small synchronous FIFO that buffers long-latency results until the RF write
// port is free. Pushes while full and pops while empty are ignored.
// Ports:
//   CLK, RST   : clock, asynchronous active-high reset (empties the FIFO)
//   push       : enqueue push_entry at the next edge
//   push_entry : entry to enqueue
//   pop        : dequeue the head at the next edge
//   head       : current oldest entry (valid only while !empty)
//   full       : FIFO_DEPTH entries held
//   empty      : no entries held
// ----------------------------------------------------------------------------
module rf_wr_fifo
  import otter_rf_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic   CLK,
  input  logic   RST,
  input  logic   push,
  input  rf_wr_t push_entry,
  input  logic   pop,
  output rf_wr_t head,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  rf_wr_t      mem [FIFO_DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// ----------------------------------------------------------------------------
// rf_write_arbiter
// Write-side controller for the pipelined OTTER register file. Merges the
// in-order pipeline writeback and a buffered long-latency result stream onto
// the single RF write port, and keeps a per-register scoreboard of results
// still owed by the long-latency unit so decode can stall on RAW hazards.
// Ports:
//   CLK, RST             : clock, asynchronous active-high reset
//   wb_valid/wb_rd/wb_data : pipeline writeback (held stable while wb_stall)
//   wb_stall             : pipeline writeback not taken this cycle
//   lu_valid/lu_rd/lu_data : long-latency result, accepted when lu_ready
//   lu_ready             : result buffer has room
//   iss_valid/iss_rd     : long-latency op issued, marks iss_rd busy
//   q_rs1/q_rs2          : decode source queries
//   hazard               : a queried source has an outstanding result
//   rf_we/rf_addr/rf_wdata : registered RF write port (WE3/A3/WD3)
// XLEN must match otter_rf_pkg::XLEN, which sizes the buffered entries.
// ----------------------------------------------------------------------------
module rf_write_arbiter #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          wb_valid,
  input  logic [otter_rf_pkg::REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]               wb_data,
  output logic                          wb_stall,
  input  logic                          lu_valid,
  output logic                          lu_ready,
  input  logic [otter_rf_pkg::REG_AW-1:0] lu_rd,
  input  logic [XLEN-1:0]               lu_data,
  input  logic                          iss_valid,
  input  logic [otter_rf_pkg::REG_AW-1:0] iss_rd,
  input  logic [otter_rf_pkg::REG_AW-1:0] q_rs1,
  input  logic [otter_rf_pkg::REG_AW-1:0] q_rs2,
  output logic                          hazard,
  output logic                          rf_we,
  output logic [otter_rf_pkg::REG_AW-1:0] rf_addr,
  output logic [XLEN-1:0]               rf_wdata
);

  import otter_rf_pkg::*;

  // Counter only has to reach STARVE_MAX-1; at that value the head is popped.
  localparam int CW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;

  rf_wr_t              push_entry;
  rf_wr_t              head;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                wb_live;
  logic                take_wb;
  logic [CW-1:0]       starve_cnt;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic                from_lu_p1;

  // ---- stage 0: accept, grant and hazard (combinational) ----
  assign lu_ready   = !full;
  assign push       = lu_valid && !full;
  assign push_entry = '{rd: lu_rd, data: lu_data, from_lu: 1'b1};

  // A writeback to x0 is swallowed without occupying the port.
  assign wb_live  = wb_valid && (wb_rd != '0);
  assign wb_stall = !empty && (starve_cnt == CW'(STARVE_MAX - 1));
  assign take_wb  = wb_live && !wb_stall;
  assign pop      = !empty && !take_wb;

  // busy[0] is held at 0, so x0 queries never raise a hazard.
  assign hazard = busy[q_rs1] | busy[q_rs2];

  rf_wr_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // ---- stage 1: registered RF write port ----
  // from_lu_p1 remembers where the current rf_* write came from so that only
  // long-latency writes retire scoreboard entries.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rf_we      <= 1'b0;
      rf_addr    <= '0;
      rf_wdata   <= '0;
      from_lu_p1 <= 1'b0;
    end else if (take_wb) begin
      rf_we      <= 1'b1;
      rf_addr    <= wb_rd;
      rf_wdata   <= wb_data;
      from_lu_p1 <= 1'b0;
    end else if (pop) begin
      // Buffered results aimed at x0 are drained without a write.
      rf_we      <= (head.rd != '0);
      rf_addr    <= head.rd;
      rf_wdata   <= head.data;
      from_lu_p1 <= head.from_lu;
    end else begin
      rf_we      <= 1'b0;
    end
  end

  // Counts cycles the head has waited behind the pipeline.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      starve_cnt <= '0;
    end else if (empty || pop) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  // Retire on the edge the long-latency write commits; a new issue to the
  // same register in that cycle is applied last and so wins.
  always_comb begin
    busy_next = busy;
    if (rf_we && from_lu_p1) busy_next[rf_addr] = 1'b0;
    if (iss_valid)           busy_next[iss_rd]  = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

  localparam int XLEN       = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int STARVE_MAX = 8;

  logic            CLK = 1'b0;
  logic            RST;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            wb_stall;
  logic            lu_valid;
  logic            lu_ready;
  logic [4:0]      lu_rd;
  logic [XLEN-1:0] lu_data;
  logic            iss_valid;
  logic [4:0]      iss_rd;
  logic [4:0]      q_rs1;
  logic [4:0]      q_rs2;
  logic            hazard;
  logic            rf_we;
  logic [4:0]      rf_addr;
  logic [XLEN-1:0] rf_wdata;

  always #5 CLK = ~CLK;

  rf_write_arbiter #(
    .XLEN(XLEN), .FIFO_DEPTH(FIFO_DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .CLK(CLK), .RST(RST),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_stall(wb_stall),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .hazard(hazard),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending long-latency results as a queue, a wait count
  // for the oldest one, a busy flag per register and the expected RF write.
  logic [4:0]      m_q_rd[$];
  logic [XLEN-1:0] m_q_data[$];
  int              m_wait;
  bit [31:0]       m_busy;
  bit              m_we;
  logic [4:0]      m_addr;
  logic [XLEN-1:0] m_data;
  bit              m_from_lu;

  function automatic bit exp_stall();
    return (m_q_rd.size() > 0) && (m_wait == STARVE_MAX - 1);
  endfunction

  function automatic bit exp_hazard();
    return ((q_rs1 != 0) && m_busy[q_rs1]) || ((q_rs2 != 0) && m_busy[q_rs2]);
  endfunction

  task automatic model_reset();
    m_q_rd.delete();
    m_q_data.delete();
    m_wait    = 0;
    m_busy    = '0;
    m_we      = 1'b0;
    m_addr    = '0;
    m_data    = '0;
    m_from_lu = 1'b0;
  endtask

  // Apply the current inputs to the model as the coming clock edge would.
  task automatic model_step();
    bit              stall;
    bit              push_ok;
    logic [4:0]      hrd;
    logic [XLEN-1:0] hdata;
    stall   = exp_stall();
    push_ok = lu_valid && (m_q_rd.size() < FIFO_DEPTH);
    if (m_we && m_from_lu) m_busy[m_addr] = 1'b0;
    if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    if (stall || (!(wb_valid && wb_rd != 0) && m_q_rd.size() > 0)) begin
      hrd       = m_q_rd.pop_front();
      hdata     = m_q_data.pop_front();
      m_we      = (hrd != 0);
      m_addr    = hrd;
      m_data    = hdata;
      m_from_lu = 1'b1;
      m_wait    = 0;
    end else if (wb_valid && wb_rd != 0) begin
      m_we      = 1'b1;
      m_addr    = wb_rd;
      m_data    = wb_data;
      m_from_lu = 1'b0;
      m_wait    = (m_q_rd.size() > 0) ? m_wait + 1 : 0;
    end else begin
      m_we   = 1'b0;
      m_wait = 0;
    end
    if (push_ok) begin
      m_q_rd.push_back(lu_rd);
      m_q_data.push_back(lu_data);
    end
  endtask

  task automatic idle();
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0;
    iss_valid = 0; iss_rd = 0; q_rs1 = 0; q_rs2 = 0;
  endtask

  task automatic advance();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    idle();
    RST = 1'b1;
    model_reset();
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we: got %b expected 0", rf_we); end
    n_checks++; if (rf_addr !== 5'd0) begin n_fail++; $display("FAIL reset_rf_addr: got %0d expected 0", rf_addr); end
    n_checks++; if (rf_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_rf_wdata: got %h expected 0", rf_wdata); end
    n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL reset_hazard: got %b expected 0", hazard); end
    n_checks++; if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_lu_ready: got %b expected 1", lu_ready); end
    n_checks++; if (wb_stall !== 1'b0) begin n_fail++; $display("FAIL reset_wb_stall: got %b expected 0", wb_stall); end
    advance();
  endtask

  task automatic test_wb_write();
    wb_valid = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
    @(negedge CLK);
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL wb_pre_we: got %b expected 0", rf_we); end
    advance();
    idle();
    @(negedge CLK);
    n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL wb_we: got %b expected 1", rf_we); end
    n_checks++; if (rf_addr !== 5'd5) begin n_fail++; $display("FAIL wb_addr: got %0d expected 5", rf_addr); end
    n_checks++; if (rf_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wb_data: got %h expected deadbeef", rf_wdata); end
    advance();
    @(negedge CLK);
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL wb_pulse_end: got %b expected 0", rf_we); end
    advance();
  endtask

  task automatic test_scoreboard();
    iss_valid = 1; iss_rd = 7; q_rs1 = 7;
    @(negedge CLK);
    n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL sb_before_issue: got %b expected 0", hazard); end
    advance();
    iss_valid = 0; lu_valid = 1; lu_rd = 7; lu_data = 32'h1234;
    @(negedge CLK);
    n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL sb_busy: got %b expected 1", hazard); end
    advance();
    lu_valid = 0;
    @(negedge CLK);
    n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL sb_buffered: got %b expected 1", hazard); end
    advance();
    @(negedge CLK);
    n_checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd7 || rf_wdata !== 32'h1234) begin
      n_fail++; $display("FAIL sb_write: got we=%b addr=%0d data=%h expected we=1 addr=7 data=1234", rf_we, rf_addr, rf_wdata); end
    n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL sb_during_write: got %b expected 1", hazard); end
    advance();
    q_rs1 = 0; q_rs2 = 7;
    @(negedge CLK);
    n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL sb_cleared: got %b expected 0", hazard); end
    advance();
    idle();
  endtask

  task automatic test_starve();
    wb_valid = 1; wb_rd = 3; wb_data = 32'hA5A50003;
    lu_valid = 1; lu_rd = 9; lu_data = 32'h99;
    @(negedge CLK);
    n_checks++; if (wb_stall !== 1'b0) begin n_fail++; $display("FAIL starve_push: got %b expected 0", wb_stall); end
    advance();
    lu_valid = 0;
    for (int k = 1; k <= STARVE_MAX; k++) begin
      @(negedge CLK);
      n_checks++; if (wb_stall !== (k == STARVE_MAX)) begin
        n_fail++; $display("FAIL starve_wait%0d: got %b expected %b", k, wb_stall, (k == STARVE_MAX)); end
      advance();
    end
    @(negedge CLK);
    n_checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd9 || rf_wdata !== 32'h99) begin
      n_fail++; $display("FAIL starve_fifo_write: got we=%b addr=%0d data=%h expected 1/9/99", rf_we, rf_addr, rf_wdata); end
    n_checks++; if (wb_stall !== 1'b0) begin n_fail++; $display("FAIL starve_after: got %b expected 0", wb_stall); end
    advance();
    @(negedge CLK);
    n_checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd3) begin
      n_fail++; $display("FAIL starve_wb_write: got we=%b addr=%0d expected 1/3", rf_we, rf_addr); end
    idle();
    advance();
  endtask

  task automatic test_fifo_full();
    wb_valid = 1; wb_rd = 2; wb_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      lu_valid = 1; lu_rd = 5'(10 + i); lu_data = 32'(256 + i);
      @(negedge CLK);
      n_checks++; if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready%0d: got %b expected 1", i, lu_ready); end
      advance();
    end
    for (int c = 4; c <= 8; c++) begin
      lu_valid = 1; lu_rd = 5'd14; lu_data = 32'h1E;
      @(negedge CLK);
      n_checks++; if (lu_ready !== 1'b0 || wb_stall !== (c == 8)) begin
        n_fail++; $display("FAIL full_hold%0d: got ready=%b stall=%b expected ready=0 stall=%b", c, lu_ready, wb_stall, (c == 8)); end
      advance();
    end
    lu_valid = 0;
    @(negedge CLK);
    n_checks++; if (lu_ready !== 1'b1 || rf_we !== 1'b1 || rf_addr !== 5'd10) begin
      n_fail++; $display("FAIL full_first_pop: got ready=%b we=%b addr=%0d expected 1/1/10", lu_ready, rf_we, rf_addr); end
    advance();
    wb_valid = 0;
    @(negedge CLK);
    n_checks++; if (rf_addr !== 5'd2) begin n_fail++; $display("FAIL full_wb_retry: got %0d expected 2", rf_addr); end
    advance();
    for (int i = 11; i <= 13; i++) begin
      @(negedge CLK);
      n_checks++; if (rf_we !== 1'b1 || rf_addr !== 5'(i)) begin
        n_fail++; $display("FAIL full_drain%0d: got we=%b addr=%0d expected 1/%0d", i, rf_we, rf_addr, i); end
      advance();
    end
    @(negedge CLK);
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL full_no_fifth: got we=%b addr=%0d expected 0", rf_we, rf_addr); end
    advance();
  endtask

  task automatic test_x0();
    wb_valid = 1; wb_rd = 6; wb_data = 32'h66;
    lu_valid = 1; lu_rd = 4; lu_data = 32'h44;
    advance();
    wb_rd = 0; wb_data = 32'h77; lu_valid = 0;
    iss_valid = 1; iss_rd = 0; q_rs1 = 0; q_rs2 = 0;
    @(negedge CLK);
    n_checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd6) begin
      n_fail++; $display("FAIL x0_prev_wb: got we=%b addr=%0d expected 1/6", rf_we, rf_addr); end
    advance();
    wb_valid = 0; iss_valid = 0;
    lu_valid = 1; lu_rd = 0; lu_data = 32'h55;
    @(negedge CLK);
    n_checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd4 || rf_wdata !== 32'h44) begin
      n_fail++; $display("FAIL x0_fifo_wins: got we=%b addr=%0d data=%h expected 1/4/44", rf_we, rf_addr, rf_wdata); end
    n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL x0_busy: got %b expected 0", hazard); end
    advance();
    lu_valid = 0;
    @(negedge CLK);
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL x0_wb_dropped: got %b expected 0", rf_we); end
    advance();
    @(negedge CLK);
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL x0_fifo_dropped: got we=%b addr=%0d expected 0", rf_we, rf_addr); end
    advance();
  endtask

  task automatic test_reset_mid();
    wb_valid = 1; wb_rd = 6; wb_data = 32'h1;
    lu_valid = 1; lu_rd = 20; lu_data = 32'h2;
    iss_valid = 1; iss_rd = 20; q_rs1 = 20;
    advance();
    lu_rd = 21; iss_valid = 0;
    @(negedge CLK);
    n_checks++; if (rf_we !== 1'b1 || hazard !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre: got we=%b hazard=%b expected 1/1", rf_we, hazard); end
    advance();
    #2;
    RST = 1'b1;
    model_reset();
    #1;
    n_checks++; if (rf_we !== 1'b0 || lu_ready !== 1'b1 || hazard !== 1'b0 || wb_stall !== 1'b0) begin
      n_fail++; $display("FAIL mid_async: got we=%b ready=%b hazard=%b stall=%b expected 0/1/0/0", rf_we, lu_ready, hazard, wb_stall); end
    idle();
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL mid_after%0d: got we=%b addr=%0d expected 0", i, rf_we, rf_addr); end
      advance();
    end
  endtask

  task automatic test_random();
    bit hold;
    int wb_pct;
    hold = 1'b0;
    for (int i = 0; i < 600; i++) begin
      wb_pct = (i < 300) ? 60 : 92;
      if (!hold) begin
        wb_valid = ($urandom_range(0, 99) < wb_pct);
        wb_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        wb_data  = $urandom;
      end
      lu_valid  = ($urandom_range(0, 99) < 35);
      lu_rd     = 5'($urandom_range(0, 31));
      lu_data   = $urandom;
      iss_valid = ($urandom_range(0, 99) < 25);
      iss_rd    = 5'($urandom_range(0, 31));
      q_rs1     = 5'($urandom_range(0, 31));
      q_rs2     = 5'($urandom_range(0, 31));
      @(negedge CLK);
      n_checks++; if (lu_ready !== (m_q_rd.size() < FIFO_DEPTH)) begin
        n_fail++; $display("FAIL rnd_lu_ready@%0d: got %b expected %b", i, lu_ready, (m_q_rd.size() < FIFO_DEPTH)); end
      n_checks++; if (wb_stall !== exp_stall()) begin
        n_fail++; $display("FAIL rnd_wb_stall@%0d: got %b expected %b", i, wb_stall, exp_stall()); end
      n_checks++; if (hazard !== exp_hazard()) begin
        n_fail++; $display("FAIL rnd_hazard@%0d: got %b expected %b", i, hazard, exp_hazard()); end
      n_checks++; if (rf_we !== m_we) begin
        n_fail++; $display("FAIL rnd_rf_we@%0d: got %b expected %b", i, rf_we, m_we); end
      if (m_we) begin
        n_checks++; if (rf_addr !== m_addr || rf_wdata !== m_data) begin
          n_fail++; $display("FAIL rnd_rf_write@%0d: got %0d/%h expected %0d/%h", i, rf_addr, rf_wdata, m_addr, m_data); end
      end
      // Pipeline freezes its writeback while stalled.
      hold = exp_stall();
      advance();
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_wb_write();
    test_scoreboard();
    test_starve();
    test_fifo_full();
    test_x0();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
